pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
Top-level game sequencer for the Pong display. It owns the game state machine, both players' two-digit BCD scores and the remaining-ball count. It drives the score/ball digits and the text-region enables consumed by the text overlay, and freezes or relaunches the graphics engine. It sits between the paddle/ball graphics block (which reports misses) and the text overlay and pixel mux.

Parameters:
BALLS, 3, balls per game; loaded into ball on game start; must be 1..3.
HOLD_FRAMES, 120, frames (about 2 s at 60 Hz) spent in NEWBALL and OVER before advancing.
TW, 8, hold-timer width; requires HOLD_FRAMES < 2**TW.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
btn  input  1  synchronized level, OR of the player buttons
refr_tick  input  1  one-cycle pulse at each frame start
miss_l  input  1  one-cycle pulse: left paddle missed the ball
miss_r  input  1  one-cycle pulse: right paddle missed the ball
dig0  output  4  left score ones digit (BCD)
dig1  output  4  left score tens digit (BCD)
dig2  output  4  right score ones digit (BCD)
dig3  output  4  right score tens digit (BCD)
ball  output  2  balls remaining
text_en  output  4  region enables, ordered {score, logo, rule, over}
graph_still  output  1  1 = graphics engine frozen, ball parked
launch  output  1  one-cycle pulse: graphics block re-centres and serves the ball

Behaviour:
- Reset values (asynchronous on reset_n low, all registered):
  - state = NEWGAME
  - dig0..dig3 = 0
  - ball = BALLS
  - timer = 0
  - btn_q = 0
  - launch = 0
- Outputs during and after reset:
  - text_en = 4'b1110
  - graph_still = 1
- Button edge: btn_q is btn registered. btn_rise = btn & ~btn_q. Only rising edges advance the FSM, so a held button never re-triggers.
- States:
  - NEWGAME
    - text_en = 4'b1110; graph_still = 1.
    - On btn_rise: clear all four digits, set ball = BALLS, pulse launch, go to PLAY.
    - The previous game's score stays visible until this point.
  - PLAY
    - text_en = 4'b1000; graph_still = 0.
    - miss_l adds 1 to the right score (dig3:dig2). miss_r adds 1 to the left score (dig1:dig0).
    - On any miss (miss_l | miss_r):
      - ball decrements by exactly 1, including when both misses arrive in the same cycle (both scores still increment).
      - If ball was 1, go to OVER. Otherwise go to NEWBALL.
      - timer is cleared on that transition.
  - NEWBALL
    - text_en = 4'b1000; graph_still = 1.
    - timer increments on each refr_tick, saturating at HOLD_FRAMES.
    - When timer == HOLD_FRAMES and btn_rise: pulse launch, go to PLAY.
    - btn_rise before the hold expires is ignored.
  - OVER
    - text_en = 4'b1001; graph_still = 1.
    - timer counts as in NEWBALL. When timer == HOLD_FRAMES, go to NEWGAME (no button needed).
    - Scores and ball are held.
- Miss pulses outside PLAY are ignored.
- BCD increment, per player:
  - ones < 9: ones + 1.
  - ones == 9: ones = 0, tens + 1.
  - 99 wraps to 00.
  - Digits never leave 0..9.
- Latency: outputs update on the clk edge after the triggering input. launch is high for exactly one cycle, coincident with state becoming PLAY.
- refr_tick and miss_* may coincide; each is handled independently in the same cycle.
- Reset mid-game returns immediately to NEWGAME with the reset values above.

Test Plan:
1. Reset, hold btn low for 1000 cycles -> state NEWGAME, text_en=1110, graph_still=1, ball=3, digits all 0, launch never asserted.
2. btn rise, then three miss_r pulses each followed by 120 refr_ticks and a btn rise:
   - launch fires once per serve.
   - ball goes 3->2->1->0.
   - dig1:dig0 = 0:3.
   - After the third miss text_en=1001.
   - After 120 more refr_ticks, state is NEWGAME with the scores still shown.
3. In NEWBALL, press btn after 50 refr_ticks -> no launch. Press again after tick 120 -> launch pulses, graph_still=0.
4. Force the left score to 0:9, then a miss_r -> 1:0. From 9:9, a miss_r -> 0:0.
5. miss_l and miss_r in the same cycle with ball=2 -> both scores +1, ball=1, state NEWBALL.
6. Deassert reset_n mid-PLAY, asynchronously to clk -> outputs take reset values immediately. Hold btn high across reset release -> no start until btn goes low then high.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: game FSM, two-digit BCD scores per player, ball count,
// text-overlay region enables and graphics freeze/launch control.
module pong_game_ctrl #(
  parameter int BALLS       = 3,
  parameter int HOLD_FRAMES = 120,
  parameter int TW          = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn,
  input  logic       refr_tick,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [1:0] ball,
  output logic [3:0] text_en,
  output logic       graph_still,
  output logic       launch
);

  typedef enum logic [1:0] {NEWGAME, PLAY, NEWBALL, OVER} state_e;

  localparam logic [TW-1:0] HOLD       = TW'(HOLD_FRAMES);
  localparam logic [1:0]    BALLS_INIT = 2'(BALLS);

  state_e        state_q, state_d;
  logic [7:0]    left_q, left_d;     // {tens, ones}
  logic [7:0]    right_q, right_d;
  logic [1:0]    ball_q, ball_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          btn_q, armed_q, launch_q, launch_d;
  logic          btn_rise;
  logic [TW-1:0] timer_inc;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      return {((v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1), 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // A button already held when reset releases must go low once before it
  // can start a game, so rises are only honoured after a low has been seen.
  assign btn_rise  = btn & ~btn_q & armed_q;
  assign timer_inc = (refr_tick && (timer_q != HOLD)) ? timer_q + TW'(1) : timer_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    left_d      = left_q;
    right_d     = right_q;
    ball_d      = ball_q;
    timer_d     = timer_q;
    launch_d    = 1'b0;
    text_en     = 4'b1110;
    graph_still = 1'b1;

    unique case (state_q)
      NEWGAME: begin
        if (btn_rise) begin
          left_d   = 8'h00;
          right_d  = 8'h00;
          ball_d   = BALLS_INIT;
          launch_d = 1'b1;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        text_en     = 4'b1000;
        graph_still = 1'b0;
        if (miss_l) right_d = bcd_inc(right_q);
        if (miss_r) left_d  = bcd_inc(left_q);
        // A double miss still costs only one ball.
        if (miss_l || miss_r) begin
          ball_d  = ball_q - 2'd1;
          timer_d = '0;
          state_d = (ball_q == 2'd1) ? OVER : NEWBALL;
        end
      end
      NEWBALL: begin
        text_en = 4'b1000;
        timer_d = timer_inc;
        if ((timer_q == HOLD) && btn_rise) begin
          launch_d = 1'b1;
          state_d  = PLAY;
        end
      end
      OVER: begin
        text_en = 4'b1001;
        timer_d = timer_inc;
        if (timer_q == HOLD) state_d = NEWGAME;
      end
      default: state_d = NEWGAME;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= NEWGAME;
      left_q   <= 8'h00;
      right_q  <= 8'h00;
      ball_q   <= BALLS_INIT;
      timer_q  <= '0;
      btn_q    <= 1'b0;
      armed_q  <= 1'b0;
      launch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      left_q   <= left_d;
      right_q  <= right_d;
      ball_q   <= ball_d;
      timer_q  <= timer_d;
      btn_q    <= btn;
      armed_q  <= armed_q | ~btn;
      launch_q <= launch_d;
    end
  end

  assign dig0   = left_q[3:0];
  assign dig1   = left_q[7:4];
  assign dig2   = right_q[3:0];
  assign dig3   = right_q[7:4];
  assign ball   = ball_q;
  assign launch = launch_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: each serve pushes the expected ball count and
// scores; a monitor pops and compares on every launch pulse.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn, refr_tick, miss_l, miss_r;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic [1:0] ball;
  logic [3:0] text_en;
  logic       graph_still, launch;

  typedef struct packed {
    logic [1:0]  ball;
    logic [15:0] digs;  // {dig3, dig2, dig1, dig0}
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pong_game_ctrl #(.BALLS(3), .HOLD_FRAMES(120), .TW(8)) dut (
    .clk(clk), .reset_n(reset_n), .btn(btn), .refr_tick(refr_tick),
    .miss_l(miss_l), .miss_r(miss_r),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .ball(ball), .text_en(text_en), .graph_still(graph_still), .launch(launch)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every launch must match the oldest expected serve.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && launch) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_launch: got launch=1, expected no launch");
        end else begin
          e = exp_q.pop_front();
          check("launch_ball", 32'(ball), 32'(e.ball));
          check("launch_digs", 32'({dig3, dig2, dig1, dig0}), 32'(e.digs));
          check("launch_still", 32'(graph_still), 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press();
    btn = 1'b1; tick();
    btn = 1'b0; tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      refr_tick = 1'b1; tick();
      refr_tick = 1'b0; tick();
    end
  endtask

  task automatic miss(input logic l, input logic r);
    miss_l = l; miss_r = r; tick();
    miss_l = 1'b0; miss_r = 1'b0;
  endtask

  task automatic serve(input logic [1:0] b, input logic [15:0] d);
    exp_t e;
    e.ball = b;
    e.digs = d;
    exp_q.push_back(e);
    press();
  endtask

  task automatic check_state(input string name, input logic [1:0] b,
                             input logic [15:0] d, input logic [3:0] te,
                             input logic gs);
    check({name, "_ball"}, 32'(ball), 32'(b));
    check({name, "_digs"}, 32'({dig3, dig2, dig1, dig0}), 32'(d));
    check({name, "_text"}, 32'(text_en), 32'(te));
    check({name, "_still"}, 32'(graph_still), 32'(gs));
  endtask

  initial begin
    reset_n = 1'b0; btn = 1'b0; refr_tick = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
    #22;
    check_state("in_reset", 2'd3, 16'h0000, 4'b1110, 1'b1);
    check("in_reset_launch", 32'(launch), 32'd0);
    #1 reset_n = 1'b1;

    // Idle with button low: stays in NEWGAME, no launch.
    cycles(1000);
    check_state("idle", 2'd3, 16'h0000, 4'b1110, 1'b1);

    // Full game, right paddle keeps winning the left player points.
    serve(2'd3, 16'h0000);
    check_state("play1", 2'd3, 16'h0000, 4'b1000, 1'b0);
    miss(1'b0, 1'b1);
    check_state("miss1", 2'd2, 16'h0001, 4'b1000, 1'b1);
    frames(120);
    serve(2'd2, 16'h0001);
    miss(1'b0, 1'b1);
    check_state("miss2", 2'd1, 16'h0002, 4'b1000, 1'b1);
    frames(120);
    serve(2'd1, 16'h0002);
    miss(1'b0, 1'b1);
    check_state("over", 2'd0, 16'h0003, 4'b1001, 1'b1);
    frames(119);
    check("over_hold_text", 32'(text_en), 32'(4'b1001));
    frames(1);
    check_state("back_newgame", 2'd0, 16'h0003, 4'b1110, 1'b1);

    // Early press in NEWBALL is ignored; press after the hold serves.
    serve(2'd3, 16'h0000);
    miss(1'b1, 1'b0);
    check_state("miss_l", 2'd2, 16'h0100, 4'b1000, 1'b1);
    frames(50);
    press();
    check("early_press_still", 32'(graph_still), 32'd1);
    frames(70);
    serve(2'd2, 16'h0100);
    check_state("late_press", 2'd2, 16'h0100, 4'b1000, 1'b0);

    // BCD carry and wrap on the left score.
    force dut.left_q = 8'h09;
    #1 release dut.left_q;
    miss(1'b0, 1'b1);
    check_state("bcd_carry", 2'd1, 16'h0110, 4'b1000, 1'b1);
    frames(120);
    serve(2'd1, 16'h0110);
    force dut.left_q = 8'h99;
    #1 release dut.left_q;
    miss(1'b0, 1'b1);
    check_state("bcd_wrap", 2'd0, 16'h0100, 4'b1001, 1'b1);
    frames(120);

    // Simultaneous misses: both scores advance, one ball lost.
    serve(2'd3, 16'h0000);
    miss(1'b0, 1'b1);
    frames(120);
    serve(2'd2, 16'h0001);
    miss(1'b1, 1'b1);
    check_state("double_miss", 2'd1, 16'h0102, 4'b1000, 1'b1);

    // Asynchronous reset mid-PLAY with the button held through release.
    frames(120);
    serve(2'd1, 16'h0102);
    cycles(3);
    #2 reset_n = 1'b0;
    btn = 1'b1;
    #1;
    check_state("async_reset", 2'd3, 16'h0000, 4'b1110, 1'b1);
    check("async_reset_launch", 32'(launch), 32'd0);
    #12 reset_n = 1'b1;
    cycles(10);
    check_state("held_btn", 2'd3, 16'h0000, 4'b1110, 1'b1);
    btn = 1'b0; tick();
    exp_q.push_back('{ball: 2'd3, digs: 16'h0000});
    btn = 1'b1; tick();
    check("restart_text", 32'(text_en), 32'(4'b1000));
    btn = 1'b0;
    cycles(3);
    check("all_serves_seen", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
